hall_sector_speed_module: RTL

HALL_SECTOR_SPEED_MODULE -- requirements
Module: hall_sector_speed_module

---
 rtl/hall_sector_speed_module.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hall_sector_speed_module.sv
// Hall sector decoder with direction, edge strobe, edge-to-edge period measurement and stall detection.
// state    | meaning
// ST_INIT  | no legal sector seen since reset or the last illegal code
// ST_SYNC  | legal sector known, no legal adjacent edge yet
// ST_RUN   | at least one legal edge seen, period measurement active
// ST_STALL | no legal edge for STALL_CNT cycles, speed reported as zero
module hall_sector_speed_module #(
    parameter logic [23:0] STALL_CNT = 24'd10_000_000,
    parameter int          PERIOD_W  = 24
) (
    input  logic                sys_clk,
    input  logic                reset_n,
    input  logic                hall_u_in,
    input  logic                hall_v_in,
    input  logic                hall_w_in,
    output logic [2:0]          hall_sector,
    output logic                sector_valid,
    output logic                dir,
    output logic                edge_pulse,
    output logic [PERIOD_W-1:0] period_cnt,
    output logic                period_valid,
    output logic                hall_err,
    output logic                stall
);

    typedef enum logic [1:0] {ST_INIT, ST_SYNC, ST_RUN, ST_STALL} state_t;

    localparam logic [PERIOD_W-1:0] STALL_LIM = PERIOD_W'(STALL_CNT);

    state_t                state, state_nxt;
    logic [2:0]            code_q, code_d;
    logic [PERIOD_W-1:0]   cnt, cnt_nxt;
    logic [2:0]            new_sec, fwd_sec, rev_sec;
    logic                  code_chg, is_fwd, is_rev;
    logic [2:0]            sector_nxt;
    logic                  valid_nxt, dir_nxt, edge_nxt, pv_nxt, err_nxt, stall_nxt;
    logic [PERIOD_W-1:0]   period_nxt;

    function automatic logic [2:0] decode_sector(input logic [2:0] code);
        case (code)
            3'b101:  decode_sector = 3'd1;
            3'b100:  decode_sector = 3'd2;
            3'b110:  decode_sector = 3'd3;
            3'b010:  decode_sector = 3'd4;
            3'b011:  decode_sector = 3'd5;
            3'b001:  decode_sector = 3'd6;
            default: decode_sector = 3'd0;
        endcase
    endfunction

    always_comb begin
        new_sec    = decode_sector(code_q);
        code_chg   = (code_q != code_d);
        fwd_sec    = (hall_sector == 3'd6) ? 3'd1 : hall_sector + 3'd1;
        rev_sec    = (hall_sector == 3'd1) ? 3'd6 : hall_sector - 3'd1;
        is_fwd     = (new_sec == fwd_sec);
        is_rev     = (new_sec == rev_sec);

        state_nxt  = state;
        sector_nxt = hall_sector;
        valid_nxt  = sector_valid;
        dir_nxt    = dir;
        edge_nxt   = 1'b0;
        period_nxt = period_cnt;
        pv_nxt     = 1'b0;
        err_nxt    = 1'b0;
        stall_nxt  = stall;
        if (state == ST_INIT || cnt == '1) begin
            cnt_nxt = cnt;
        end else begin
            cnt_nxt = cnt + PERIOD_W'(1);
        end

        if (code_chg && new_sec == 3'd0) begin
            err_nxt    = 1'b1;
            valid_nxt  = 1'b0;
            sector_nxt = 3'd0;
            stall_nxt  = 1'b0;
            cnt_nxt    = '0;
            state_nxt  = ST_INIT;
        end else if (state == ST_INIT) begin
            if (new_sec != 3'd0) begin
                sector_nxt = new_sec;
                valid_nxt  = 1'b1;
                cnt_nxt    = '0;
                state_nxt  = ST_SYNC;
            end
        end else if (code_chg && (is_fwd || is_rev)) begin
            // Only a same-direction edge following another RUN edge yields a period
            if (state == ST_RUN && is_fwd == dir) begin
                period_nxt = cnt;
                pv_nxt     = 1'b1;
            end
            edge_nxt   = 1'b1;
            sector_nxt = new_sec;
            dir_nxt    = is_fwd;
            stall_nxt  = 1'b0;
            cnt_nxt    = PERIOD_W'(1);
            state_nxt  = ST_RUN;
        end else if (code_chg && new_sec != hall_sector) begin
            err_nxt    = 1'b1;
            sector_nxt = new_sec;
            stall_nxt  = 1'b0;
            cnt_nxt    = '0;
            state_nxt  = ST_SYNC;
        end else if (state != ST_STALL && cnt >= STALL_LIM) begin
            stall_nxt  = 1'b1;
            period_nxt = '1;
            pv_nxt     = 1'b1;
            state_nxt  = ST_STALL;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_INIT;
            code_q       <= 3'd0;
            code_d       <= 3'd0;
            cnt          <= '0;
            hall_sector  <= 3'd0;
            sector_valid <= 1'b0;
            dir          <= 1'b1;
            edge_pulse   <= 1'b0;
            period_cnt   <= '0;
            period_valid <= 1'b0;
            hall_err     <= 1'b0;
            stall        <= 1'b0;
        end else begin
            state        <= state_nxt;
            code_q       <= {hall_u_in, hall_v_in, hall_w_in};
            code_d       <= code_q;
            cnt          <= cnt_nxt;
            hall_sector  <= sector_nxt;
            sector_valid <= valid_nxt;
            dir          <= dir_nxt;
            edge_pulse   <= edge_nxt;
            period_cnt   <= period_nxt;
            period_valid <= pv_nxt;
            hall_err     <= err_nxt;
            stall        <= stall_nxt;
        end
    end

endmodule
